// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding, transfer
// size codes and the latched bus request record.
package bus_pkg;

    // Widths of the latched request record; the arbiter is built for these.
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Transfer size codes carried on bus_size / data_size.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Arbiter states: idle, then address and data phase for each requester.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    // Request fields captured at grant time and held on the bus.
    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access.
// Fixed priority data over inst, one outstanding transaction, and squashed
// fetches are drained off the bus without being delivered to IF.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rvalid,
    output logic              stallreq_from_if,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_rvalid,
    output logic              stallreq_from_mem,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    // The latched request record is sized by the package widths.
    if (ADDR_W != BUS_ADDR_W || DATA_W != BUS_DATA_W) begin : g_width_check
        $error("mem_bus_arbiter: ADDR_W/DATA_W must match bus_pkg widths");
    end

    state_t            state_reg, state_next;
    bus_req_t          req_reg, req_next;
    logic              discard_reg, discard_next;
    logic [DATA_W-1:0] inst_rdata_reg, inst_rdata_next;
    logic [DATA_W-1:0] data_rdata_reg, data_rdata_next;
    logic              inst_rvalid_reg, inst_rvalid_next;
    logic              data_rvalid_reg, data_rvalid_next;

    // State and latch registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            req_reg         <= '0;
            discard_reg     <= 1'b0;
            inst_rdata_reg  <= '0;
            data_rdata_reg  <= '0;
            inst_rvalid_reg <= 1'b0;
            data_rvalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            discard_reg     <= discard_next;
            inst_rdata_reg  <= inst_rdata_next;
            data_rdata_reg  <= data_rdata_next;
            inst_rvalid_reg <= inst_rvalid_next;
            data_rvalid_reg <= data_rvalid_next;
        end
    end

    // Arbitration, bus handshake sequencing and completion bookkeeping.
    always_comb begin
        state_next       = state_reg;
        req_next         = req_reg;
        discard_next     = discard_reg;
        inst_rdata_next  = inst_rdata_reg;
        data_rdata_next  = data_rdata_reg;
        inst_rvalid_next = 1'b0;
        data_rvalid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                discard_next = 1'b0;
                // A requester whose rvalid is high this cycle is finishing,
                // not asking again, so it is not re-accepted.
                if (data_req && !data_rvalid_reg) begin
                    req_next   = '{wr: data_wr, size: data_size,
                                   addr: data_addr, wdata: data_wdata};
                    state_next = ST_D_ADDR;
                end else if (inst_req && !inst_rvalid_reg && !flush) begin
                    req_next   = '{wr: 1'b0, size: SIZE_WORD,
                                   addr: inst_addr, wdata: '0};
                    state_next = ST_I_ADDR;
                end
            end
            ST_I_ADDR: begin
                // The fetch cannot be withdrawn before addr_ok; mark it dead.
                if (flush) discard_next = 1'b1;
                if (bus_addr_ok) state_next = ST_I_DATA;
            end
            ST_I_DATA: begin
                if (flush) discard_next = 1'b1;
                if (bus_data_ok) begin
                    if (!(discard_reg || flush)) begin
                        inst_rdata_next  = bus_rdata;
                        inst_rvalid_next = 1'b1;
                    end
                    discard_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            ST_D_ADDR: begin
                if (bus_addr_ok) state_next = ST_D_DATA;
            end
            ST_D_DATA: begin
                if (bus_data_ok) begin
                    // Writes complete with a pulse but leave read data alone.
                    if (!req_reg.wr) data_rdata_next = bus_rdata;
                    data_rvalid_next = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                discard_next = 1'b0;
            end
        endcase
    end

    assign bus_req   = (state_reg == ST_I_ADDR) || (state_reg == ST_D_ADDR);
    assign bus_wr    = req_reg.wr;
    assign bus_size  = req_reg.size;
    assign bus_addr  = req_reg.addr;
    assign bus_wdata = req_reg.wdata;

    assign inst_rdata  = inst_rdata_reg;
    assign inst_rvalid = inst_rvalid_reg;
    assign data_rdata  = data_rdata_reg;
    assign data_rvalid = data_rvalid_reg;

    // IF keeps stalling while a squashed fetch is still draining off the bus.
    assign stallreq_from_if  = (inst_req && !inst_rvalid_reg) ||
                               (((state_reg == ST_I_ADDR) || (state_reg == ST_I_DATA))
                                && discard_reg);
    assign stallreq_from_mem = data_req && !data_rvalid_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the bus slave is played cycle by cycle.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        stallreq_from_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        stallreq_from_mem;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_rvalid(inst_rvalid), .stallreq_from_if(stallreq_from_if),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_rvalid(data_rvalid), .stallreq_from_mem(stallreq_from_mem),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Advance to just after the next active edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the middle of the cycle, where outputs are sampled.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = '0; data_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        mid();
        checks++; if ({bus_req, bus_wr, bus_size} !== 4'b0) begin errors++; $display("FAIL rst_bus_ctrl got=%b exp=0000", {bus_req, bus_wr, bus_size}); end
        checks++; if ({bus_addr, bus_wdata} !== 64'h0) begin errors++; $display("FAIL rst_bus_fields got=%h exp=0", {bus_addr, bus_wdata}); end
        checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", {inst_rdata, data_rdata}); end
        checks++; if ({inst_rvalid, data_rvalid, stallreq_from_if, stallreq_from_mem} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {inst_rvalid, data_rvalid, stallreq_from_if, stallreq_from_mem}); end
        $display("reset: outputs sampled after release");
        tick();
    endtask

    task automatic test_fetch();
        // cycle 0
        inst_req = 1; inst_addr = 32'hBFC00000;
        mid();
        checks++; if (stallreq_from_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got=%b exp=1", stallreq_from_if); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fetch_busreq_c0 got=%b exp=0", bus_req); end
        tick();
        // cycle 1
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_wr, bus_size} !== 4'b1010) begin errors++; $display("FAIL fetch_bus_ctrl_c1 got=%b exp=1010", {bus_req, bus_wr, bus_size}); end
        checks++; if (bus_addr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_bus_addr got=%h exp=bfc00000", bus_addr); end
        checks++; if (stallreq_from_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got=%b exp=1", stallreq_from_if); end
        tick();
        // cycle 2
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C080001;
        mid();
        checks++; if ({bus_req, inst_rvalid, stallreq_from_if} !== 3'b001) begin errors++; $display("FAIL fetch_c2 got=%b exp=001", {bus_req, inst_rvalid, stallreq_from_if}); end
        tick();
        // cycle 3
        bus_data_ok = 0;
        mid();
        checks++; if (inst_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid_c3 got=%b exp=1", inst_rvalid); end
        checks++; if (inst_rdata !== 32'h3C080001) begin errors++; $display("FAIL fetch_rdata got=%h exp=3c080001", inst_rdata); end
        checks++; if ({stallreq_from_if, bus_req} !== 2'b00) begin errors++; $display("FAIL fetch_c3_stall_busreq got=%b exp=00", {stallreq_from_if, bus_req}); end
        tick();
        // cycle 4: request dropped, nothing re-issued
        inst_req = 0;
        mid();
        checks++; if ({inst_rvalid, bus_req} !== 2'b00) begin errors++; $display("FAIL fetch_c4 got=%b exp=00", {inst_rvalid, bus_req}); end
        $display("fetch: addr=bfc00000 rdata=%h", inst_rdata);
        tick();
    endtask

    task automatic test_priority();
        // cycle 0: both request
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
        inst_req = 1; inst_addr = 32'hBFC00004;
        mid();
        checks++; if ({stallreq_from_if, stallreq_from_mem} !== 2'b11) begin errors++; $display("FAIL prio_stalls_c0 got=%b exp=11", {stallreq_from_if, stallreq_from_mem}); end
        tick();
        // cycle 1: data on the bus
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_wr, bus_size} !== 4'b1010) begin errors++; $display("FAIL prio_data_ctrl got=%b exp=1010", {bus_req, bus_wr, bus_size}); end
        checks++; if (bus_addr !== 32'h80000010) begin errors++; $display("FAIL prio_data_addr got=%h exp=80000010", bus_addr); end
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11223344;
        tick();
        // cycle 3: data completes; inst is accepted now
        bus_data_ok = 0;
        mid();
        checks++; if ({data_rvalid, inst_rvalid, bus_req, stallreq_from_mem} !== 4'b1000) begin errors++; $display("FAIL prio_c3 got=%b exp=1000", {data_rvalid, inst_rvalid, bus_req, stallreq_from_mem}); end
        checks++; if (data_rdata !== 32'h11223344) begin errors++; $display("FAIL prio_data_rdata got=%h exp=11223344", data_rdata); end
        tick();
        // cycle 4: inst goes to the bus
        data_req = 0; bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, data_rvalid} !== 2'b10) begin errors++; $display("FAIL prio_inst_busreq got=%b exp=10", {bus_req, data_rvalid}); end
        checks++; if (bus_addr !== 32'hBFC00004) begin errors++; $display("FAIL prio_inst_addr got=%h exp=bfc00004", bus_addr); end
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5555AAAA;
        tick();
        bus_data_ok = 0;
        mid();
        checks++; if ({inst_rvalid, data_rvalid} !== 2'b10) begin errors++; $display("FAIL prio_inst_rvalid got=%b exp=10", {inst_rvalid, data_rvalid}); end
        checks++; if (inst_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL prio_inst_rdata got=%h exp=5555aaaa", inst_rdata); end
        tick();
        inst_req = 0;
        mid();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL prio_no_reissue got=%b exp=0", bus_req); end
        $display("priority: data rdata=%h then inst rdata=%h", data_rdata, inst_rdata);
        tick();
    endtask

    task automatic test_write();
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'h000000AB;
        tick();
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_wr, bus_size} !== 4'b1100) begin errors++; $display("FAIL wr_ctrl got=%b exp=1100", {bus_req, bus_wr, bus_size}); end
        checks++; if ({bus_addr, bus_wdata} !== {32'h80000003, 32'h000000AB}) begin errors++; $display("FAIL wr_addr_wdata got=%h exp=80000003000000ab", {bus_addr, bus_wdata}); end
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_data_ok = 0;
        mid();
        checks++; if (data_rvalid !== 1'b1) begin errors++; $display("FAIL wr_rvalid got=%b exp=1", data_rvalid); end
        checks++; if (data_rdata !== 32'h11223344) begin errors++; $display("FAIL wr_rdata_held got=%h exp=11223344", data_rdata); end
        $display("write: addr=80000003 wdata=ab size=0");
        tick();
        data_req = 0; data_wr = 0;
        tick();
    endtask

    task automatic test_delayed_addr_ok();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000020;
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus_addr_ok = (c == 4);
            mid();
            checks++; if ({bus_req, stallreq_from_mem} !== 2'b11) begin errors++; $display("FAIL dly_req_stall_c%0d got=%b exp=11", c, {bus_req, stallreq_from_mem}); end
            checks++; if (bus_addr !== 32'h80000020) begin errors++; $display("FAIL dly_addr_c%0d got=%h exp=80000020", c, bus_addr); end
            tick();
        end
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
        mid();
        checks++; if ({bus_req, stallreq_from_mem} !== 2'b01) begin errors++; $display("FAIL dly_c5 got=%b exp=01", {bus_req, stallreq_from_mem}); end
        tick();
        bus_data_ok = 0;
        mid();
        checks++; if ({data_rvalid, stallreq_from_mem} !== 2'b10) begin errors++; $display("FAIL dly_c6 got=%b exp=10", {data_rvalid, stallreq_from_mem}); end
        checks++; if (data_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL dly_rdata got=%h exp=cafef00d", data_rdata); end
        $display("delayed: addr=80000020 rdata=%h", data_rdata);
        tick();
        data_req = 0;
        tick();
    endtask

    task automatic test_flush();
        // flush in IDLE blocks acceptance
        inst_req = 1; inst_addr = 32'hBFC0000C; flush = 1;
        tick();
        flush = 0;
        mid();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flush_idle_block got=%b exp=0", bus_req); end
        tick();
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'hBFC0000C}) begin errors++; $display("FAIL flush_fetch_issue got=%h exp=1bfc0000c", {bus_req, bus_addr}); end
        tick();
        // I_DATA: flush arrives before data_ok
        bus_addr_ok = 0; flush = 1;
        tick();
        // data_ok for the squashed fetch; IF not requesting, stall from discard
        flush = 0; inst_req = 0; bus_data_ok = 1; bus_rdata = 32'h12345678;
        mid();
        checks++; if (stallreq_from_if !== 1'b1) begin errors++; $display("FAIL flush_discard_stall got=%b exp=1", stallreq_from_if); end
        tick();
        bus_data_ok = 0; inst_req = 1; inst_addr = 32'h00000040;
        mid();
        checks++; if ({inst_rvalid, bus_req} !== 2'b00) begin errors++; $display("FAIL flush_no_rvalid got=%b exp=00", {inst_rvalid, bus_req}); end
        checks++; if (inst_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL flush_rdata_held got=%h exp=5555aaaa", inst_rdata); end
        tick();
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h00000040}) begin errors++; $display("FAIL flush_vector_issue got=%h exp=100000040", {bus_req, bus_addr}); end
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0800000A;
        tick();
        bus_data_ok = 0;
        mid();
        checks++; if ({inst_rvalid, inst_rdata} !== {1'b1, 32'h0800000A}) begin errors++; $display("FAIL flush_vector_done got=%h exp=10800000a", {inst_rvalid, inst_rdata}); end
        $display("flush: squashed bfc0000c, vector 00000040 rdata=%h", inst_rdata);
        tick();
        inst_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000030;
        tick();
        bus_addr_ok = 1;
        tick();
        // D_DATA: reset abandons the access
        bus_addr_ok = 0; rst = 1;
        tick();
        rst = 0; data_req = 0; bus_data_ok = 1; bus_rdata = 32'h99999999;
        mid();
        checks++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== 68'h0) begin errors++; $display("FAIL rstmid_bus got=%h exp=0", {bus_req, bus_wr, bus_size, bus_addr, bus_wdata}); end
        checks++; if ({inst_rdata, data_rdata, inst_rvalid, data_rvalid, stallreq_from_if, stallreq_from_mem} !== 68'h0) begin errors++; $display("FAIL rstmid_outs got=%h exp=0", {inst_rdata, data_rdata, inst_rvalid, data_rvalid, stallreq_from_if, stallreq_from_mem}); end
        tick();
        bus_data_ok = 0;
        mid();
        checks++; if ({data_rvalid, bus_req, data_rdata} !== 34'h0) begin errors++; $display("FAIL rstmid_late_dataok got=%h exp=0", {data_rvalid, bus_req, data_rdata}); end
        $display("reset_mid: access to 80000030 abandoned");
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_delayed_addr_ok();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
